pdp1_cycle_timer: RTL and testbench

//  Generates the PDP-1 5 us memory-cycle timing pulse chain tp[0..10] at 50 MHz (20 ns/tick).

---
 rtl/pdp1_cycle_timer.sv | 114 +++++++++++
 tb/tb_pdp1_cycle_timer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pdp1_cycle_timer.sv
// pdp1_cycle_timer: PDP-1 5 us memory-cycle pulse chain tp[0..10] at 50 MHz.
// One counter walks 0..PERIOD-1 per memory cycle. Each tp bit decodes one
// counter value while the chain is running. An IOT in-out hold can freeze the
// counter just after tp[7], and a stop or single-cycle request lets the
// current cycle finish before the chain goes idle.
module pdp1_cycle_timer #(
  parameter int PERIOD     = 250,
  parameter int TP_FIRST   = 0,
  parameter int TP_SPACING = 25,
  parameter int HOLD_AT    = 176,
  parameter int CW         = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        single,
  input  logic        io_hold,
  input  logic        io_done,
  output logic [10:0] tp,
  output logic        busy,
  output logic        held,
  output logic        cyc_end
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST     = CW'(PERIOD - 1);
  localparam logic [CW-1:0] HOLD_CNT = CW'(HOLD_AT);
  localparam logic [CW-1:0] RESUME   = CW'(HOLD_AT + 1);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          stop_pend, stop_pend_nxt;
  logic          run_q;

  // State, cycle counter and pending-stop flag; reset overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      stop_pend <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      stop_pend <= stop_pend_nxt;
    end
  end

  // Next-state logic: start/stop/hold sequencing and counter advance.
  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    stop_pend_nxt = stop_pend;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        // Capture stop here so that a stop arriving with start still
        // allows exactly one cycle to run.
        stop_pend_nxt = stop | single;
        if (start) state_nxt = RUN;
      end
      RUN: begin
        if (stop) stop_pend_nxt = 1'b1;
        if (cnt == LAST) begin
          cnt_nxt = '0;
          if (stop_pend || single) begin
            state_nxt     = IDLE;
            stop_pend_nxt = 1'b0;
          end
        end else if (cnt == HOLD_CNT && io_hold) begin
          // Freeze the counter at HOLD_AT. Any pulse decoded at this tick
          // has already been emitted during this clock.
          state_nxt = HOLD;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      HOLD: begin
        if (stop) stop_pend_nxt = 1'b1;
        if (io_done) begin
          state_nxt = RUN;
          cnt_nxt   = RESUME;
        end
      end
      default: begin
        state_nxt     = IDLE;
        cnt_nxt       = '0;
        stop_pend_nxt = 1'b0;
      end
    endcase
  end

  // Pulses are suppressed while reset is asserted, so the reset cycle
  // never emits a stray pulse even when the chain was mid-cycle.
  assign run_q = (state == RUN) && !reset;

  // One decoder per timing pulse tp[0..9], spaced TP_SPACING ticks apart.
  for (genvar n = 0; n < 10; n++) begin : g_tp
    localparam logic [CW-1:0] AT = CW'(TP_FIRST + n * TP_SPACING);
    assign tp[n] = run_q && (cnt == AT);
  end

  // tp[10] always marks the last tick of the cycle.
  assign tp[10]  = run_q && (cnt == LAST);
  assign cyc_end = tp[10];
  assign busy    = (state != IDLE) && !reset;
  assign held    = (state == HOLD) && !reset;

endmodule

// File: tb/tb_pdp1_cycle_timer.sv
// tb_pdp1_cycle_timer: constant timing tables, directed corner sequences and
// randomized traffic compared against a behavioural cycle model.
`timescale 1ns/1ps
module tb_pdp1_cycle_timer;

  localparam int PERIOD = 250;
  localparam int SP     = 25;
  localparam int HOLD   = 176;

  logic        clk = 1'b0;
  logic        reset, start, stop, single, io_hold, io_done;
  logic [10:0] tp;
  logic        busy, held, cyc_end;

  pdp1_cycle_timer dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .single(single),
    .io_hold(io_hold), .io_done(io_done), .tp(tp), .busy(busy), .held(held),
    .cyc_end(cyc_end)
  );

  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // Behavioural model: running flag, position within the 250-tick cycle,
  // frozen flag for the IOT hold, and a pending-stop request.
  bit m_on, m_frozen, m_stop;
  int m_pos;

  // Outputs sampled mid-cycle by step().
  logic [10:0] s_tp;
  logic        s_busy, s_held, s_end;

  typedef struct {
    int          scen;
    int          clk;
    logic [10:0] tp;
    logic        busy;
    logic        held;
    logic        cyc_end;
  } vec_t;

  localparam int NV = 10;
  vec_t vec [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, act, exp);
    end
  endtask

  // One clock: check outputs at the falling edge, then advance the model
  // with the inputs that the rising edge samples.
  task automatic step();
    logic [10:0] etp;
    bit          was;
    cyc++;
    @(negedge clk);
    etp = '0;
    if (!reset && m_on && !m_frozen) begin
      if (m_pos == PERIOD - 1) etp[10] = 1'b1;
      else if (m_pos % SP == 0 && m_pos / SP < 10) etp[m_pos / SP] = 1'b1;
    end
    chk("tp", 32'(tp), 32'(etp));
    chk("busy", 32'(busy), 32'(!reset && m_on));
    chk("held", 32'(held), 32'(!reset && m_on && m_frozen));
    chk("cyc_end", 32'(cyc_end), 32'(etp[10]));
    s_tp = tp; s_busy = busy; s_held = held; s_end = cyc_end;
    @(posedge clk);
    if (reset) begin
      m_on = 0; m_frozen = 0; m_stop = 0; m_pos = 0;
    end else if (!m_on) begin
      m_stop = stop | single;
      if (start) begin m_on = 1; m_pos = 0; end
    end else if (m_frozen) begin
      if (stop) m_stop = 1;
      if (io_done) begin m_frozen = 0; m_pos = HOLD + 1; end
    end else begin
      was = m_stop;
      if (stop) m_stop = 1;
      if (m_pos == PERIOD - 1) begin
        if (was || single) begin m_on = 0; m_stop = 0; end
        m_pos = 0;
      end else if (m_pos == HOLD && io_hold) begin
        m_frozen = 1;
      end else begin
        m_pos++;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    reset = 1; start = 0; stop = 0; single = 0; io_hold = 0; io_done = 0;
    repeat (3) step();
    reset = 0;
    cyc = 0;
  endtask

  initial begin
    int cnt_a, cnt_b;

    // Timing table: scenario 0 = continuous run, 1 = single cycle; start at clk 10.
    vec[0] = '{0, 10,  11'h000, 1'b0, 1'b0, 1'b0};
    vec[1] = '{0, 11,  11'h001, 1'b1, 1'b0, 1'b0};
    vec[2] = '{0, 36,  11'h002, 1'b1, 1'b0, 1'b0};
    vec[3] = '{0, 186, 11'h080, 1'b1, 1'b0, 1'b0};
    vec[4] = '{0, 259, 11'h000, 1'b1, 1'b0, 1'b0};
    vec[5] = '{0, 260, 11'h400, 1'b1, 1'b0, 1'b1};
    vec[6] = '{0, 261, 11'h001, 1'b1, 1'b0, 1'b0};
    vec[7] = '{1, 11,  11'h001, 1'b1, 1'b0, 1'b0};
    vec[8] = '{1, 260, 11'h400, 1'b1, 1'b0, 1'b1};
    vec[9] = '{1, 261, 11'h000, 1'b0, 1'b0, 1'b0};

    m_on = 0; m_frozen = 0; m_stop = 0; m_pos = 0;
    do_reset();
    chk("reset_tp", 32'(s_tp), 32'h0);
    chk("reset_busy", 32'(s_busy), 32'h0);

    for (int s = 0; s < 2; s++) begin
      do_reset();
      single = s[0];
      for (int c = 1; c <= 270; c++) begin
        start = (c == 10);
        step();
        for (int i = 0; i < NV; i++) begin
          if (vec[i].scen == s && vec[i].clk == cyc) begin
            chk("vec_tp", 32'(s_tp), 32'(vec[i].tp));
            chk("vec_busy", 32'(s_busy), 32'(vec[i].busy));
            chk("vec_held", 32'(s_held), 32'(vec[i].held));
            chk("vec_cyc_end", 32'(s_end), 32'(vec[i].cyc_end));
          end
        end
      end
    end

    // Stop at cnt=40 finishes the current cycle, then stays quiet.
    do_reset();
    cnt_a = 0;
    for (int c = 1; c <= 800; c++) begin
      start = (c == 10);
      stop  = (c == 51);
      step();
      if (c == 260) chk("stop_tp10", 32'(s_tp), 32'h400);
      if (c == 261) chk("stop_idle", 32'(s_busy), 32'h0);
      if (c >= 262 && s_tp != 0) cnt_a++;
    end
    chk("stop_quiet", cnt_a, 0);

    // IOT hold through cnt 176, io_done 300 clks after the freeze.
    do_reset();
    io_hold = 1;
    cnt_a = 0; cnt_b = 0;
    for (int c = 1; c <= 520; c++) begin
      start   = (c == 10);
      io_done = (c == 488);
      step();
      if (s_tp[7]) cnt_a++;
      if (c >= 188 && c <= 488 && s_tp != 0) cnt_b++;
      if (c == 187) chk("hold_pre", 32'(s_held), 32'h0);
      if (c == 300) chk("hold_held", 32'(s_held), 32'h1);
      if (c == 489) chk("hold_release", 32'(s_held), 32'h0);
      if (c == 511) chk("hold_tp8_early", 32'(s_tp), 32'h0);
      if (c == 512) chk("hold_tp8", 32'(s_tp), 32'h100);
    end
    io_hold = 0; io_done = 0;
    chk("hold_tp7_once", cnt_a, 1);
    chk("hold_silent", cnt_b, 0);

    // Reset while held, and again at cnt=100; restart needs a fresh start.
    do_reset();
    cnt_a = 0;
    for (int c = 1; c <= 600; c++) begin
      start   = (c == 10 || c == 410);
      reset   = (c == 300 || c == 511);
      io_hold = (c < 400);
      step();
      if (c == 299) chk("rst_was_held", 32'(s_held), 32'h1);
      if (c == 301 || c == 512) begin
        chk("rst_tp", 32'(s_tp), 32'h0);
        chk("rst_busy", 32'(s_busy), 32'h0);
        chk("rst_held", 32'(s_held), 32'h0);
      end
      if (c == 510) chk("rst_cnt99", 32'(s_tp), 32'h0);
      if ((c > 301 && c <= 410) || c > 512) cnt_a += int'(s_busy);
    end
    reset = 0; io_hold = 0;
    chk("rst_needs_start", cnt_a, 0);

    // start and stop in the same idle clock: exactly one cycle.
    do_reset();
    cnt_a = 0;
    for (int c = 1; c <= 600; c++) begin
      start = (c == 10);
      stop  = (c == 10);
      step();
      cnt_a += $countones(s_tp);
      if (c == 261) chk("ss_idle", 32'(s_busy), 32'h0);
    end
    stop = 0;
    chk("ss_one_cycle", cnt_a, 11);

    // Randomized traffic against the model.
    do_reset();
    for (int c = 0; c < 8000; c++) begin
      start   = ($urandom_range(39) == 0);
      stop    = ($urandom_range(149) == 0);
      io_done = ($urandom_range(59) == 0);
      reset   = ($urandom_range(1999) == 0);
      if ($urandom_range(499) == 0) single  = ~single;
      if ($urandom_range(299) == 0) io_hold = ~io_hold;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
